dmem_dma: RTL and testbench

DMEM_DMA -- requirements
Module: dmem_dma

---
 rtl/dmem_pkg.sv | 14 +
 rtl/dmem_dma.sv | 109 ++++++++++
 tb/tb_dmem_dma.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared widths and FSM encoding for the data-memory copy engine.
package dmem_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/dmem_dma.sv
// Byte-wise memory-to-memory copy engine sharing one data-memory port with the CPU.
// The CPU always wins the port; a contended READ/WRITE cycle simply stalls the engine.
module dmem_dma
  import dmem_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [ADDR_W-1:0] SrcAddr,
  input  logic [ADDR_W-1:0] DstAddr,
  input  logic [ADDR_W-1:0] Len,
  input  logic              CpuReq,
  input  logic              CpuWe,
  input  logic [ADDR_W-1:0] CpuAddr,
  input  logic [DATA_W-1:0] CpuDin,
  output logic [DATA_W-1:0] CpuDout,
  input  logic [DATA_W-1:0] MemDout,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemDin,
  output logic              MemWe,
  output logic              Busy,
  output logic              Done
);

  state_t              state;
  logic [ADDR_W-1:0]   src;
  logic [ADDR_W-1:0]   dst;
  logic [ADDR_W-1:0]   cnt;
  logic [DATA_W-1:0]   buffer;

  assign CpuDout = MemDout;

  // Transfer sequencing; only the memory-touching states yield to the CPU.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= IDLE;
      src    <= '0;
      dst    <= '0;
      cnt    <= '0;
      buffer <= '0;
      Busy   <= 1'b0;
      Done   <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            src  <= SrcAddr;
            dst  <= DstAddr;
            cnt  <= Len;
            Busy <= 1'b1;
            if (Len != '0) begin
              state <= READ;
            end else begin
              state <= DONE;
              Done  <= 1'b1;
            end
          end
        end
        READ: begin
          if (!CpuReq) begin
            buffer <= MemDout;
            state  <= WRITE;
          end
        end
        WRITE: begin
          if (!CpuReq) begin
            src <= src + ADDR_W'(1);
            dst <= dst + ADDR_W'(1);
            cnt <= cnt - ADDR_W'(1);
            if (cnt == ADDR_W'(1)) begin
              state <= DONE;
              Done  <= 1'b1;
            end else begin
              state <= READ;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

  // Port mux: CPU first, then the engine; a pending reset blocks any engine write.
  always_comb begin
    MemAddr = '0;
    MemDin  = '0;
    MemWe   = 1'b0;
    if (CpuReq) begin
      MemAddr = CpuAddr;
      MemDin  = CpuDin;
      MemWe   = CpuWe;
    end else if (!Reset && state == READ) begin
      MemAddr = src;
    end else if (!Reset && state == WRITE) begin
      MemAddr = dst;
      MemDin  = buffer;
      MemWe   = 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_dma.sv
// Directed bench for dmem_dma attached to a 256x8 combinational-read data memory.
module tb_dmem_dma;

  logic       Clk;
  logic       Reset;
  logic       Start;
  logic [7:0] SrcAddr;
  logic [7:0] DstAddr;
  logic [7:0] Len;
  logic       CpuReq;
  logic       CpuWe;
  logic [7:0] CpuAddr;
  logic [7:0] CpuDin;
  logic [7:0] CpuDout;
  logic [7:0] MemDout;
  logic [7:0] MemAddr;
  logic [7:0] MemDin;
  logic       MemWe;
  logic       Busy;
  logic       Done;

  logic [7:0] mem [256];
  int total;
  int bad;
  int we_cnt;

  dmem_dma dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Start   (Start),
    .SrcAddr (SrcAddr),
    .DstAddr (DstAddr),
    .Len     (Len),
    .CpuReq  (CpuReq),
    .CpuWe   (CpuWe),
    .CpuAddr (CpuAddr),
    .CpuDin  (CpuDin),
    .CpuDout (CpuDout),
    .MemDout (MemDout),
    .MemAddr (MemAddr),
    .MemDin  (MemDin),
    .MemWe   (MemWe),
    .Busy    (Busy),
    .Done    (Done)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  assign MemDout = mem[MemAddr];

  always @(posedge Clk) begin
    if (MemWe === 1'b1) begin
      mem[MemAddr] <= MemDin;
      we_cnt = we_cnt + 1;
    end
  end

  task automatic check8(input string name, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Start a copy, optionally hand the port to the CPU (write 5A to 0x05) on cycles st_lo..st_hi.
  task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                          input int st_lo, input int st_hi, input int exp_done, input string name);
    int first_done;
    int n_done;
    first_done = -1;
    n_done = 0;
    Start = 1'b1; SrcAddr = s; DstAddr = d; Len = l;
    @(posedge Clk); #1;
    Start = 1'b0;
    for (int k = 1; k <= exp_done + 3; k++) begin
      if (Done === 1'b1) begin
        n_done++;
        if (first_done < 0) first_done = k;
      end
      if (k == 1) begin
        total++;
        if (Busy !== 1'b1) begin
          bad++;
          $display("FAIL %s busy_cycle1: got %b want 1", name, Busy);
        end
      end
      if (k >= st_lo && k <= st_hi) begin
        CpuReq = 1'b1; CpuWe = 1'b1; CpuAddr = 8'h05; CpuDin = 8'h5A;
        #1;
        total++;
        if (MemAddr !== 8'h05 || MemWe !== 1'b1 || MemDin !== 8'h5A) begin
          bad++;
          $display("FAIL %s cpu_port_c%0d: got addr=%h we=%b din=%h want 05/1/5a",
                   name, k, MemAddr, MemWe, MemDin);
        end
      end else begin
        CpuReq = 1'b0; CpuWe = 1'b0;
      end
      @(posedge Clk); #1;
    end
    CpuReq = 1'b0; CpuWe = 1'b0;
    total++;
    if (first_done != exp_done) begin
      bad++;
      $display("FAIL %s done_cycle: got %0d want %0d", name, first_done, exp_done);
    end
    total++;
    if (n_done != 1) begin
      bad++;
      $display("FAIL %s done_pulses: got %0d want 1", name, n_done);
    end
    total++;
    if (Busy !== 1'b0) begin
      bad++;
      $display("FAIL %s busy_after: got %b want 0", name, Busy);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start = 1'b1; SrcAddr = 8'h10; DstAddr = 8'h80; Len = 8'h04;
    @(posedge Clk); @(posedge Clk); #1;
    total++;
    if (Busy !== 1'b0 || Done !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags: got busy=%b done=%b want 0/0", Busy, Done);
    end
    check8("reset_memaddr", MemAddr, 8'h00);
    check8("reset_memdin", MemDin, 8'h00);
    total++;
    if (MemWe !== 1'b0) begin
      bad++;
      $display("FAIL reset_memwe: got %b want 0", MemWe);
    end
    Reset = 1'b0; Start = 1'b0;
    @(posedge Clk); #1;
    total++;
    if (Busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_start_precedence: got busy=%b want 0", Busy);
    end
  endtask

  task automatic test_basic();
    mem[8'h10] = 8'hA1; mem[8'h11] = 8'hB2; mem[8'h12] = 8'hC3; mem[8'h13] = 8'hD4;
    for (int i = 8'h80; i <= 8'h83; i++) mem[i] = 8'h00;
    run_copy(8'h10, 8'h80, 8'h04, 0, -1, 9, "basic");
    check8("basic_m80", mem[8'h80], 8'hA1);
    check8("basic_m81", mem[8'h81], 8'hB2);
    check8("basic_m82", mem[8'h82], 8'hC3);
    check8("basic_m83", mem[8'h83], 8'hD4);
    check8("idle_memaddr", MemAddr, 8'h00);
    check8("cpu_dout", CpuDout, mem[8'h00]);
  endtask

  task automatic test_cpu_stall();
    for (int i = 8'h80; i <= 8'h83; i++) mem[i] = 8'h00;
    mem[8'h05] = 8'h00;
    run_copy(8'h10, 8'h80, 8'h04, 2, 4, 12, "stall");
    check8("stall_m80", mem[8'h80], 8'hA1);
    check8("stall_m81", mem[8'h81], 8'hB2);
    check8("stall_m82", mem[8'h82], 8'hC3);
    check8("stall_m83", mem[8'h83], 8'hD4);
    check8("stall_m05", mem[8'h05], 8'h5A);
  endtask

  task automatic test_wrap();
    mem[8'hFE] = 8'h11; mem[8'hFF] = 8'h22; mem[8'h00] = 8'h33;
    for (int i = 8'h40; i <= 8'h42; i++) mem[i] = 8'h00;
    run_copy(8'hFE, 8'h40, 8'h03, 0, -1, 7, "wrap");
    check8("wrap_m40", mem[8'h40], 8'h11);
    check8("wrap_m41", mem[8'h41], 8'h22);
    check8("wrap_m42", mem[8'h42], 8'h33);
  endtask

  task automatic test_len0();
    int we0;
    we0 = we_cnt;
    run_copy(8'h10, 8'h60, 8'h00, 0, -1, 1, "len0");
    total++;
    if (we_cnt != we0) begin
      bad++;
      $display("FAIL len0_no_write: got %0d writes want 0", we_cnt - we0);
    end
  endtask

  task automatic test_reset_abort();
    int we0;
    int n_done;
    mem[8'h50] = 8'hEE;
    for (int i = 8'h90; i <= 8'h93; i++) mem[i] = 8'h00;
    mem[8'hA0] = 8'h00;
    we0 = we_cnt;
    n_done = 0;
    Start = 1'b1; SrcAddr = 8'h10; DstAddr = 8'h90; Len = 8'h04;
    @(posedge Clk); #1;
    Start = 1'b0;
    @(posedge Clk); #1;
    Start = 1'b1; SrcAddr = 8'h50; DstAddr = 8'hA0; Len = 8'h01;
    @(posedge Clk); #1;
    Start = 1'b0;
    @(posedge Clk); #1;
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    total++;
    if (Busy !== 1'b0 || Done !== 1'b0) begin
      bad++;
      $display("FAIL abort_flags: got busy=%b done=%b want 0/0", Busy, Done);
    end
    for (int k = 0; k < 10; k++) begin
      @(posedge Clk); #1;
      if (Done === 1'b1) n_done++;
    end
    total++;
    if (n_done != 0) begin
      bad++;
      $display("FAIL abort_no_done: got %0d pulses want 0", n_done);
    end
    total++;
    if (we_cnt - we0 != 1) begin
      bad++;
      $display("FAIL abort_writes: got %0d want 1", we_cnt - we0);
    end
    check8("abort_m90", mem[8'h90], 8'hA1);
    check8("abort_m91", mem[8'h91], 8'h00);
    check8("abort_mA0", mem[8'hA0], 8'h00);
  endtask

  task automatic test_overlap();
    mem[8'h20] = 8'h77;
    for (int i = 8'h21; i <= 8'h23; i++) mem[i] = 8'h00;
    run_copy(8'h20, 8'h21, 8'h03, 0, -1, 7, "overlap");
    check8("overlap_m21", mem[8'h21], 8'h77);
    check8("overlap_m22", mem[8'h22], 8'h77);
    check8("overlap_m23", mem[8'h23], 8'h77);
  endtask

  initial begin
    total = 0; bad = 0; we_cnt = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    Reset = 1'b1; Start = 1'b0; SrcAddr = '0; DstAddr = '0; Len = '0;
    CpuReq = 1'b0; CpuWe = 1'b0; CpuAddr = '0; CpuDin = '0;
    test_reset();
    test_basic();
    test_cpu_stall();
    test_wrap();
    test_len0();
    test_reset_abort();
    test_overlap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
